// File: rtl/fir_pkg.sv
// Shared parameters, derived widths and helpers for the parametrised FIR.
// Imported by the interface, the round/saturate stage and the top level.
package fir_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_FRAC   = 6;
  localparam int DEF_TAPS   = 4;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int acc_w(input int dw, input int cw,
                               input int taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic longint sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  localparam int PROD_W = prod_w(DEF_DATA_W, DEF_COEF_W);
  localparam int ACC_W  = acc_w(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

  localparam longint SAT_MAX = sat_max(DEF_DATA_W);
  localparam longint SAT_MIN = sat_min(DEF_DATA_W);

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample/coefficient bus of the FIR: master drives x, mode, clr and
// coefficient writes; slave returns ce_out, y and sat.
interface fir_filter_param_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS
);
  localparam int AW = clog2(TAPS);

  logic                     clk_enable;
  logic signed [DATA_W-1:0] x;
  logic                     mode;
  logic                     clr;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     ce_out;
  logic signed [DATA_W-1:0] y;
  logic                     sat;

  modport master (
    output clk_enable, x, mode, clr,
    output coef_we, coef_addr, coef_data,
    input  ce_out, y, sat
  );

  modport slave (
    input  clk_enable, x, mode, clr,
    input  coef_we, coef_addr, coef_data,
    output ce_out, y, sat
  );
endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and clamp of the accumulator to DATA_W.
// Ports: acc in (ACC_W, signed), result out (DATA_W), sat out.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W  = fir_pkg::ACC_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);
  // one guard bit so the rounding bias cannot wrap
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF =
    RW'(2 ** (FRAC - 1));
  localparam logic signed [RW-1:0] MAXV =
    RW'(sat_max(DATA_W));
  localparam logic signed [RW-1:0] MINV =
    RW'(sat_min(DATA_W));

  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  always_comb begin
    biased  = RW'(acc) + HALF;
    shifted = biased >>> FRAC;
    result  = shifted[DATA_W-1:0];
    sat     = 1'b0;
    if (shifted > MAXV) begin
      result = MAXV[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shifted < MINV) begin
      result = MINV[DATA_W-1:0];
      sat    = 1'b1;
    end
  end
endmodule

// File: rtl/fir_filter_param.sv
// Signed direct-form FIR: delay line, writable coefs, product stage,
// round/saturate output, bypass and clear. Ports: clk, rst (sync, low), bus.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int TAPS   = DEF_TAPS
) (
  input logic              clk,
  input logic              rst,
  fir_filter_param_if.slave bus
);
  localparam int AW   = clog2(TAPS);
  localparam int PW   = prod_w(DATA_W, COEF_W);
  localparam int ACCW = acc_w(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] tap  [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0]     prod [TAPS];

  logic                     v0, v1;
  logic                     m0, m1;
  logic signed [DATA_W-1:0] byp;

  logic signed [ACCW-1:0]   acc;
  logic signed [DATA_W-1:0] rs_y;
  logic                     rs_sat;

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++)
      acc = acc + ACCW'(prod[k]);
  end

  fir_round_sat #(
    .ACC_W  (ACCW),
    .FRAC   (FRAC),
    .DATA_W (DATA_W)
  ) u_rs (
    .acc    (acc),
    .result (rs_y),
    .sat    (rs_sat)
  );

  // out-of-range addresses match no k and are dropped
  always_ff @(posedge clk) begin
    for (int k = 0; k < TAPS; k++) begin
      if (!rst)
        coef[k] <= '0;
      else if (bus.coef_we && bus.coef_addr == AW'(k))
        coef[k] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      for (int k = 0; k < TAPS; k++)
        tap[k] <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v0 <= bus.clk_enable;
      v1 <= v0;
      if (bus.clk_enable) begin
        tap[0] <= bus.x;
        for (int k = 1; k < TAPS; k++)
          tap[k] <= tap[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++)
        prod[k] <= '0;
      m0  <= 1'b0;
      m1  <= 1'b0;
      byp <= '0;
    end else begin
      if (bus.clk_enable && !bus.clr)
        m0 <= bus.mode;
      for (int k = 0; k < TAPS; k++)
        prod[k] <= PW'(tap[k]) * PW'(coef[k]);
      m1  <= m0;
      byp <= tap[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.ce_out <= 1'b0;
      bus.y      <= '0;
      bus.sat    <= 1'b0;
    end else begin
      bus.ce_out <= v1;
      if (v1) begin
        bus.y   <= m1 ? byp : rs_y;
        bus.sat <= m1 ? 1'b0 : rs_sat;
      end
    end
  end
endmodule

// File: tb/tb_fir_filter_param.sv
// Directed-vector bench for fir_filter_param and fir_round_sat.
// Each task drives one scenario and checks hand-computed results.
module tb_fir_filter_param;

  logic clk;
  logic rst;

  fir_filter_param_if #(.TAPS(4)) bus ();
  fir_filter_param_if #(.TAPS(5)) bus5 ();

  fir_filter_param #(.TAPS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fir_filter_param #(.TAPS(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  logic signed [17:0] rs_acc;
  logic signed [7:0]  rs_res;
  logic               rs_sat;

  fir_round_sat #(.ACC_W(18), .FRAC(6), .DATA_W(8)) u_rs (
    .acc    (rs_acc),
    .result (rs_res),
    .sat    (rs_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int s_x  [16];
  bit s_en [16];
  bit s_md [16];
  bit o_ce [20];
  int o_y  [20];
  bit o_sat[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clk_enable = 1'b0;
    bus.x          = '0;
    bus.mode       = 1'b0;
    bus.clr        = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
  endtask

  task automatic idle5();
    bus5.clk_enable = 1'b0;
    bus5.x          = '0;
    bus5.mode       = 1'b0;
    bus5.clr        = 1'b0;
    bus5.coef_we    = 1'b0;
    bus5.coef_addr  = '0;
    bus5.coef_data  = '0;
  endtask

  task automatic wr_coef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(a);
    bus.coef_data = 8'(d);
    step();
    bus.coef_we   = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1,
                           input int c2, input int c3);
    wr_coef(0, c0);
    wr_coef(1, c1);
    wr_coef(2, c2);
    wr_coef(3, c3);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  // result of input i is observed in slot i+2
  task automatic run(input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        bus.clk_enable = s_en[i];
        bus.x          = 8'(s_x[i]);
        bus.mode       = s_md[i];
      end else begin
        bus.clk_enable = 1'b0;
        bus.x          = '0;
        bus.mode       = 1'b0;
      end
      step();
      o_ce[i]  = bus.ce_out;
      o_y[i]   = int'(bus.y);
      o_sat[i] = bus.sat;
    end
    idle();
  endtask

  task automatic load(input int i, input int xv,
                      input bit en, input bit md);
    s_x[i]  = xv;
    s_en[i] = en;
    s_md[i] = md;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    idle5();
    step();
    step();
    n_vec++;
    if (bus.ce_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ce got=%b exp=0", bus.ce_out);
    end
    n_vec++;
    if (bus.y !== 8'sd0) begin
      n_err++;
      $display("FAIL reset_y got=%0d exp=0", bus.y);
    end
    n_vec++;
    if (bus.sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sat got=%b exp=0", bus.sat);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_identity();
    set_coefs(64, 0, 0, 0);
    do_clr();
    load(0, 5, 1, 0);
    load(1, -7, 1, 0);
    run(2);
    n_vec++;
    if (o_ce[1] !== 1'b0) begin
      n_err++;
      $display("FAIL id_early_ce got=%b exp=0", o_ce[1]);
    end
    n_vec++;
    if (o_ce[2] !== 1'b1 || o_y[2] != 5 || o_sat[2] !== 1'b0) begin
      n_err++;
      $display("FAIL id_pos got ce=%b y=%0d sat=%b exp ce=1 y=5 sat=0",
               o_ce[2], o_y[2], o_sat[2]);
    end
    n_vec++;
    if (o_ce[3] !== 1'b1 || o_y[3] != -7) begin
      n_err++;
      $display("FAIL id_neg got ce=%b y=%0d exp ce=1 y=-7",
               o_ce[3], o_y[3]);
    end
  endtask

  task automatic test_moving_avg();
    int exp_y[6] = '{10, 20, 30, 40, 40, 40};
    set_coefs(16, 16, 16, 16);
    do_clr();
    for (int i = 0; i < 6; i++)
      load(i, 40, 1, 0);
    run(6);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (o_ce[i+2] !== 1'b1 || o_y[i+2] != exp_y[i]) begin
        n_err++;
        $display("FAIL mavg[%0d] got ce=%b y=%0d exp ce=1 y=%0d",
                 i, o_ce[i+2], o_y[i+2], exp_y[i]);
      end
    end
  endtask

  task automatic test_saturation();
    set_coefs(64, 64, 64, 64);
    do_clr();
    for (int i = 0; i < 4; i++)
      load(i, 100, 1, 0);
    run(4);
    n_vec++;
    if (o_y[2] != 100 || o_sat[2] !== 1'b0) begin
      n_err++;
      $display("FAIL sat_first got y=%0d sat=%b exp y=100 sat=0",
               o_y[2], o_sat[2]);
    end
    n_vec++;
    if (o_y[5] != 127 || o_sat[5] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pos got y=%0d sat=%b exp y=127 sat=1",
               o_y[5], o_sat[5]);
    end
    do_clr();
    for (int i = 0; i < 4; i++)
      load(i, -100, 1, 0);
    run(4);
    n_vec++;
    if (o_y[2] != -100 || o_sat[2] !== 1'b0) begin
      n_err++;
      $display("FAIL sat_nfirst got y=%0d sat=%b exp y=-100 sat=0",
               o_y[2], o_sat[2]);
    end
    n_vec++;
    if (o_y[5] != -128 || o_sat[5] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_neg got y=%0d sat=%b exp y=-128 sat=1",
               o_y[5], o_sat[5]);
    end
  endtask

  task automatic test_rounding();
    int exp_y[3] = '{2, -1, 1};
    set_coefs(32, 0, 0, 0);
    do_clr();
    load(0, 3, 1, 0);
    load(1, -3, 1, 0);
    load(2, 1, 1, 0);
    run(3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (o_ce[i+2] !== 1'b1 || o_y[i+2] != exp_y[i]) begin
        n_err++;
        $display("FAIL round[%0d] got ce=%b y=%0d exp ce=1 y=%0d",
                 i, o_ce[i+2], o_y[i+2], exp_y[i]);
      end
    end
  endtask

  task automatic test_bypass_gaps();
    set_coefs(0, 32, 0, 0);
    do_clr();
    load(0, -128, 1, 1);
    load(1, 99, 0, 1);
    load(2, 22, 1, 1);
    load(3, 0, 1, 0);
    run(4);
    n_vec++;
    if (o_ce[2] !== 1'b1 || o_y[2] != -128 || o_sat[2] !== 1'b0) begin
      n_err++;
      $display("FAIL byp_min got ce=%b y=%0d sat=%b exp 1 -128 0",
               o_ce[2], o_y[2], o_sat[2]);
    end
    n_vec++;
    if (o_ce[3] !== 1'b0 || o_y[3] != -128) begin
      n_err++;
      $display("FAIL gap_hold got ce=%b y=%0d exp ce=0 y=-128",
               o_ce[3], o_y[3]);
    end
    n_vec++;
    if (o_ce[4] !== 1'b1 || o_y[4] != 22) begin
      n_err++;
      $display("FAIL byp_after_gap got ce=%b y=%0d exp ce=1 y=22",
               o_ce[4], o_y[4]);
    end
    n_vec++;
    if (o_ce[5] !== 1'b1 || o_y[5] != 11) begin
      n_err++;
      $display("FAIL byp_history got ce=%b y=%0d exp ce=1 y=11",
               o_ce[5], o_y[5]);
    end
  endtask

  task automatic test_coef_write();
    set_coefs(64, 0, 0, 0);
    do_clr();
    bus.clk_enable = 1'b1;
    bus.x          = 8'sd10;
    step();
    bus.clk_enable = 1'b0;
    wr_coef(0, 0);
    step();
    n_vec++;
    if (bus.ce_out !== 1'b1 || bus.y !== 8'sd10) begin
      n_err++;
      $display("FAIL coef_old got ce=%b y=%0d exp ce=1 y=10",
               bus.ce_out, bus.y);
    end
    load(0, 10, 1, 0);
    run(1);
    n_vec++;
    if (o_ce[2] !== 1'b1 || o_y[2] != 0) begin
      n_err++;
      $display("FAIL coef_new got ce=%b y=%0d exp ce=1 y=0",
               o_ce[2], o_y[2]);
    end
  endtask

  task automatic test_clr();
    set_coefs(64, 0, 0, 0);
    do_clr();
    bus.clk_enable = 1'b1;
    bus.x          = 8'sd20;
    bus.clr        = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.ce_out !== 1'b0) begin
        n_err++;
        $display("FAIL clr_drop[%0d] got ce=%b exp=0", i, bus.ce_out);
      end
    end
    load(0, 20, 1, 0);
    run(1);
    n_vec++;
    if (o_ce[2] !== 1'b1 || o_y[2] != 20) begin
      n_err++;
      $display("FAIL clr_keep_coef got ce=%b y=%0d exp ce=1 y=20",
               o_ce[2], o_y[2]);
    end
  endtask

  task automatic test_reset_midstream();
    set_coefs(64, 0, 0, 0);
    do_clr();
    bus.clk_enable = 1'b1;
    bus.x          = 8'sd50;
    step();
    bus.x          = 8'sd60;
    step();
    bus.clk_enable = 1'b0;
    rst            = 1'b0;
    step();
    n_vec++;
    if (bus.ce_out !== 1'b0 || bus.y !== 8'sd0) begin
      n_err++;
      $display("FAIL rst_mid got ce=%b y=%0d exp ce=0 y=0",
               bus.ce_out, bus.y);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.ce_out !== 1'b0) begin
        n_err++;
        $display("FAIL rst_discard[%0d] got ce=%b exp=0",
                 i, bus.ce_out);
      end
    end
    load(0, 50, 1, 0);
    run(1);
    n_vec++;
    if (o_ce[2] !== 1'b1 || o_y[2] != 0) begin
      n_err++;
      $display("FAIL rst_coef_clear got ce=%b y=%0d exp ce=1 y=0",
               o_ce[2], o_y[2]);
    end
  endtask

  task automatic test_addr_range();
    int exp_y[5] = '{10, 0, 0, 0, 0};
    int got_y[8];
    bit got_ce[8];
    idle5();
    bus5.coef_we = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus5.coef_addr = 3'(a);
      bus5.coef_data = (a == 0 || a >= 5) ? 8'sd64 : 8'sd0;
      step();
    end
    bus5.coef_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus5.clk_enable = (i < 5);
      bus5.x          = (i == 0) ? 8'sd10 : 8'sd0;
      step();
      got_ce[i] = bus5.ce_out;
      got_y[i]  = int'(bus5.y);
    end
    idle5();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (got_ce[i+2] !== 1'b1 || got_y[i+2] != exp_y[i]) begin
        n_err++;
        $display("FAIL addr_range[%0d] got ce=%b y=%0d exp ce=1 y=%0d",
                 i, got_ce[i+2], got_y[i+2], exp_y[i]);
      end
    end
  endtask

  task automatic test_round_sat();
    int a[6]  = '{8128, 8160, -8192, -8225, -32, -33};
    int e[6]  = '{127, 127, -128, -128, 0, -1};
    bit es[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rs_acc = 18'(a[i]);
      #1;
      n_vec++;
      if (int'(rs_res) != e[i] || rs_sat !== es[i]) begin
        n_err++;
        $display("FAIL rs[%0d] acc=%0d got r=%0d s=%b exp r=%0d s=%b",
                 i, a[i], rs_res, rs_sat, e[i], es[i]);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    rs_acc = '0;
    idle();
    idle5();
    test_reset();
    test_round_sat();
    test_identity();
    test_moving_avg();
    test_saturation();
    test_rounding();
    test_bypass_gaps();
    test_coef_write();
    test_clr();
    test_reset_midstream();
    test_addr_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
